// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry holding register presented on a valid/ready handshake.
module uart_rx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   rx_data_reg, rx_data_next;
    logic                   rx_valid_reg, rx_valid_next;
    logic                   frame_err_reg, frame_err_next;
    logic                   overrun_reg, overrun_next;
    logic                   rxd_meta_reg, rxd_s_reg;
    logic                   data_sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_reg <= 1'b1;
            rxd_s_reg    <= 1'b1;
        end else begin
            rxd_meta_reg <= uart_rxd;
            rxd_s_reg    <= rxd_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            rx_data_reg   <= '0;
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            rx_data_reg   <= rx_data_next;
            rx_valid_reg  <= rx_valid_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Each shift bit loads only when the data sample targets its own index.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    shift_reg[gi] <= 1'b0;
                end else if (data_sample && (idx_reg == IDX_W'(gi))) begin
                    shift_reg[gi] <= rxd_s_reg;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg + CNT_W'(1);
        idx_next       = idx_reg;
        data_sample    = 1'b0;
        rx_data_next   = rx_data_reg;
        rx_valid_next  = rx_valid_reg && !rx_ready;
        frame_err_next = 1'b0;
        overrun_next   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (!rxd_s_reg) state_next = S_START;
            end
            S_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    state_next = rxd_s_reg ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next    = '0;
                    data_sample = 1'b1;
                    if (idx_reg == IDX_LAST) state_next = S_STOP;
                    else                     idx_next   = idx_reg + IDX_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rxd_s_reg) begin
                        state_next = S_IDLE;
                        // A byte consumed this very cycle frees the slot for the new one.
                        if (!rx_valid_reg || rx_ready) begin
                            rx_data_next  = shift_reg;
                            rx_valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_next = '0;
                if (rxd_s_reg) state_next = S_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_reg;
    assign rx_valid  = rx_valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor logs
// transfers and error pulses, and the main sequence asserts on them.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] rx_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int valid_cycles = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) rx_q.push_back(rx_data);
        if (rx_valid) valid_cycles++;
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic clear_stats();
        rx_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        valid_cycles = 0;
    endtask

    task automatic idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_valid", 32'(rx_valid), 32'h0);
        check("reset_data", 32'(rx_data), 32'h0);
        check("reset_ferr", 32'(frame_err), 32'h0);
        check("reset_ovr", 32'(overrun), 32'h0);
        idle(20);
        clear_stats();

        // single byte
        send_frame(8'hA5, 1'b1);
        idle(32);
        check("single_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("single_data", 32'(rx_q[0]), 32'hA5);
        check("single_valid_cycles", 32'(valid_cycles), 32'd1);
        check("single_ferr", 32'(fe_cnt), 32'd0);
        check("single_ovr", 32'(ov_cnt), 32'd0);
        $display("single: got %0d byte(s)", rx_q.size());
        clear_stats();

        // back-to-back burst
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        send_frame(8'h80, 1'b1);
        idle(32);
        check("burst_count", 32'(rx_q.size()), 32'd4);
        if (rx_q.size() == 4) begin
            check("burst_b0", 32'(rx_q[0]), 32'h00);
            check("burst_b1", 32'(rx_q[1]), 32'hFF);
            check("burst_b2", 32'(rx_q[2]), 32'h55);
            check("burst_b3", 32'(rx_q[3]), 32'h80);
        end
        check("burst_errs", 32'(fe_cnt + ov_cnt), 32'd0);
        $display("burst: got %0d byte(s)", rx_q.size());
        clear_stats();

        // start-bit glitch
        uart_rxd = 1'b0;
        repeat (5) tick();
        idle(40);
        check("glitch_nobyte", 32'(valid_cycles), 32'd0);
        check("glitch_ferr", 32'(fe_cnt), 32'd0);
        send_frame(8'h3C, 1'b1);
        idle(32);
        check("glitch_next_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("glitch_next_data", 32'(rx_q[0]), 32'h3C);
        $display("glitch: got %0d byte(s) after glitch", rx_q.size());
        clear_stats();

        // framing error followed by held-low break
        send_frame(8'h12, 1'b0);
        uart_rxd = 1'b0;
        repeat (40 * CPB) tick();
        idle(2 * CPB);
        check("ferr_pulses", 32'(fe_cnt), 32'd1);
        check("ferr_nobyte", 32'(valid_cycles), 32'd0);
        send_frame(8'h34, 1'b1);
        idle(32);
        check("ferr_next_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("ferr_next_data", 32'(rx_q[0]), 32'h34);
        check("ferr_total", 32'(fe_cnt), 32'd1);
        $display("frame_err: %0d pulse(s)", fe_cnt);
        clear_stats();

        // overrun with consumer stalled
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(32);
        check("ovr_valid", 32'(rx_valid), 32'h1);
        check("ovr_data", 32'(rx_data), 32'h11);
        check("ovr_pulses", 32'(ov_cnt), 32'd1);
        rx_ready = 1'b1;
        tick();
        check("ovr_drain_valid", 32'(rx_valid), 32'h0);
        check("ovr_drain_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("ovr_drain_data", 32'(rx_q[0]), 32'h11);
        $display("overrun: %0d pulse(s), drained %0d byte(s)", ov_cnt, rx_q.size());
        idle(8);
        clear_stats();

        // reset in the middle of data bit 3
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        uart_rxd = 1'b1;
        repeat (CPB / 2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(rx_valid), 32'h0);
        check("mid_rst_data", 32'(rx_data), 32'h0);
        check("mid_rst_pulses", 32'(frame_err | overrun), 32'h0);
        idle(20 * CPB);
        check("mid_rst_nobyte", 32'(valid_cycles), 32'd0);
        check("mid_rst_ferr", 32'(fe_cnt), 32'd0);
        send_frame(8'h66, 1'b1);
        idle(32);
        check("mid_rst_next_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("mid_rst_next_data", 32'(rx_q[0]), 32'h66);
        $display("reset mid-frame: got %0d byte(s) afterwards", rx_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
